// File: rtl/tile_mac_engine.sv
// tile_mac_engine: 4x4 by 4x4 fixed-point tile multiply-accumulate.
// A single time-multiplexed MAC walks 64 (r,c,k) steps per tile pair. Sums
// accumulate across a first..last sequence of K-tiles. Each sequence emits
// one saturated, packed 4x4 result on a valid/ready port.
module tile_mac_engine #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int ACC_W = 40
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_first,
    input  logic                 in_last,
    input  logic [WIDTH*16-1:0]  in_a,
    input  logic [WIDTH*16-1:0]  in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH*16-1:0]  out_data,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, COMPUTE, HOLD} state_t;

    // Output clamp bounds, sign-extended to accumulator width.
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    state_t                    state;
    logic [5:0]                idx;
    logic [WIDTH*16-1:0]       a_q;
    logic [WIDTH*16-1:0]       b_q;
    logic                      last_q;
    logic signed [ACC_W-1:0]   acc [16];

    logic [3:0]                a_sel;
    logic [3:0]                b_sel;
    logic [3:0]                c_sel;
    logic signed [WIDTH-1:0]   a_el;
    logic signed [WIDTH-1:0]   b_el;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   acc_sum;
    logic [WIDTH*16-1:0]       result;

    // Drop the fractional bits (arithmetic shift, rounds toward -inf),
    // then clamp the value into the signed element range.
    function automatic logic [WIDTH-1:0] convert(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] s;
        s = v >>> FRAC;
        if (s > SAT_MAX)
            return SAT_MAX[WIDTH-1:0];
        else if (s < SAT_MIN)
            return SAT_MIN[WIDTH-1:0];
        else
            return s[WIDTH-1:0];
    endfunction

    // One MAC step: idx = {r, c, k}. Computes acc[4r+c] + A[r][k]*B[k][c].
    always_comb begin
        a_sel   = {idx[5:4], idx[1:0]};
        b_sel   = {idx[1:0], idx[3:2]};
        c_sel   = idx[5:2];
        a_el    = a_q[WIDTH*(15-int'(a_sel)) +: WIDTH];
        b_el    = b_q[WIDTH*(15-int'(b_sel)) +: WIDTH];
        prod    = a_el * b_el;
        acc_sum = acc[c_sel] + {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
    end

    // Result tile as it stands after the current MAC. On the final step the
    // element being updated takes the fresh sum, so the capture needs no
    // extra cycle.
    always_comb begin
        result = '0;
        for (int e = 0; e < 16; e++) begin
            result[WIDTH*(15-e) +: WIDTH] = convert((4'(e) == c_sel) ? acc_sum : acc[e]);
        end
    end

    // Control FSM, operand capture, accumulators and registered outputs.
    // NOTE: every register here, the accumulator array included, sits in the
    // async reset. A reset must leave the engine with all-zero sums, so the
    // array cannot be left out of the reset. Assignments are non-blocking so
    // that all state updates together at the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            last_q    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            for (int i = 0; i < 16; i++) acc[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        last_q   <= in_last;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= COMPUTE;
                        if (in_first) begin
                            for (int i = 0; i < 16; i++) acc[i] <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    acc[c_sel] <= acc_sum;
                    idx        <= idx + 6'd1;
                    if (idx == 6'd63) begin
                        if (last_q) begin
                            out_data  <= result;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_mac_engine.sv
// Directed testbench for tile_mac_engine. The expected values are worked out
// by hand for Q8.8 elements.
module tb_tile_mac_engine;

    localparam int W  = 16;
    localparam int DW = W * 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_first = 1'b0;
    logic          in_last = 1'b0;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          busy;

    int total = 0;
    int bad   = 0;

    tile_mac_engine #(.WIDTH(16), .FRAC(8), .ACC_W(40)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Safety net in case the design stops responding.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] splat(input logic [15:0] v);
        return {16{v}};
    endfunction

    function automatic logic [DW-1:0] diag(input logic [15:0] d);
        logic [DW-1:0] t;
        t = '0;
        for (int r = 0; r < 4; r++) t[W*(15-5*r) +: W] = d;
        return t;
    endfunction

    // Element n = 0x0100 * n.
    function automatic logic [DW-1:0] ramp();
        logic [DW-1:0] t;
        t = '0;
        for (int n = 0; n < 16; n++) t[W*(15-n) +: W] = 16'(n * 256);
        return t;
    endfunction

    // Wait (bounded) for in_ready, then present one tile pair for one cycle.
    // Inputs are scrambled afterwards so that a design sampling them late
    // gets garbage.
    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic first, input logic last);
        int n = 0;
        while (!in_ready && n < 200) begin
            tick;
            n++;
        end
        check("accept_ready", DW'(in_ready), DW'(1));
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_first = first;
        in_last  = last;
        tick;
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = ~b;
        in_first = ~first;
        in_last  = ~last;
    endtask

    // Count cycles after the accept until out_valid (bounded).
    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            tick;
            n++;
        end
    endtask

    initial begin
        int  lat;
        logic seen_valid;
        logic early_ready;
        logic [DW-1:0] held;

        // Reset state.
        repeat (3) tick;
        check("rst_in_ready", DW'(in_ready), DW'(1));
        check("rst_out_valid", DW'(out_valid), DW'(0));
        check("rst_busy", DW'(busy), DW'(0));
        check("rst_out_data", out_data, '0);
        rst = 1'b0;
        tick;

        // Identity x B: result equals B; out_valid at T+65.
        send(diag(16'h0100), ramp(), 1'b1, 1'b1);
        check("ident_busy", DW'(busy), DW'(1));
        check("ident_in_ready_low", DW'(in_ready), DW'(0));
        wait_out(lat);
        check("ident_latency", DW'(lat), DW'(64));
        check("ident_data", out_data, ramp());
        tick;
        check("ident_hs_valid", DW'(out_valid), DW'(0));
        check("ident_hs_ready", DW'(in_ready), DW'(1));

        // Constant tiles: 4 * 2.0 * 3.0 = 24.0 = 0x1800.
        send(splat(16'h0200), splat(16'h0300), 1'b1, 1'b1);
        wait_out(lat);
        check("const_latency", DW'(lat), DW'(64));
        check("const_data", out_data, splat(16'h1800));
        tick;

        // Positive saturation.
        send(splat(16'h7FFF), splat(16'h7FFF), 1'b1, 1'b1);
        wait_out(lat);
        check("satpos_data", out_data, splat(16'h7FFF));
        tick;

        // Negative saturation.
        send(splat(16'h8000), splat(16'h7FFF), 1'b1, 1'b1);
        wait_out(lat);
        check("satneg_data", out_data, splat(16'h8000));
        tick;

        // K-accumulation: first tile gives no output and is ready at T+65.
        send(diag(16'h0100), diag(16'h0100), 1'b1, 1'b0);
        seen_valid  = 1'b0;
        early_ready = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            tick;
            seen_valid = seen_valid | out_valid;
            if (i < 64) early_ready = early_ready | in_ready;
        end
        check("kacc_no_valid", DW'(seen_valid), DW'(0));
        check("kacc_no_early_ready", DW'(early_ready), DW'(0));
        check("kacc_ready_t65", DW'(in_ready), DW'(1));
        send(diag(16'h0100), diag(16'h0100), 1'b0, 1'b1);
        wait_out(lat);
        check("kacc_latency", DW'(lat), DW'(64));
        check("kacc_data", out_data, diag(16'h0200));
        tick;

        // Backpressure: result held for 10 extra cycles.
        out_ready = 1'b0;
        send(splat(16'h0200), splat(16'h0300), 1'b1, 1'b1);
        wait_out(lat);
        held = out_data;
        check("bp_data", held, splat(16'h1800));
        for (int i = 0; i < 10; i++) begin
            tick;
            check("bp_valid_held", DW'(out_valid), DW'(1));
            check("bp_data_stable", out_data, splat(16'h1800));
            check("bp_in_ready_low", DW'(in_ready), DW'(0));
        end
        out_ready = 1'b1;
        tick;
        check("bp_hs_valid", DW'(out_valid), DW'(0));
        check("bp_hs_ready", DW'(in_ready), DW'(1));

        // Reset at idx=30 aborts the tile; a fresh sequence is clean.
        send(splat(16'h7FFF), splat(16'h7FFF), 1'b1, 1'b1);
        repeat (30) tick;
        check("abort_busy_before", DW'(busy), DW'(1));
        rst = 1'b1;
        #1;
        check("abort_out_valid", DW'(out_valid), DW'(0));
        check("abort_in_ready", DW'(in_ready), DW'(1));
        check("abort_busy", DW'(busy), DW'(0));
        tick;
        rst = 1'b0;
        tick;
        send(splat(16'h0200), splat(16'h0300), 1'b1, 1'b1);
        wait_out(lat);
        check("abort_new_latency", DW'(lat), DW'(64));
        check("abort_new_data", out_data, splat(16'h1800));
        tick;
        check("abort_new_done", DW'(in_ready), DW'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
